mem_port_arbiter: RTL and testbench

// - Shares one single-ported unified memory between IF-stage fetch and MEM-stage data access.
// - Sequences each access over a req/ack handshake and drives the pipeline freeze signal.
// - Adds a starvation guard and a bus-timeout error flag.
// - Sits between the CPU pipeline registers and the external memory model.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_arb_timer.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM state encodings and
// the grant-select encoding that remembers which requester owns the bus.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_D = 2'd1,
    ST_GNT_I = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    GSEL_D = 1'b0,
    GSEL_I = 1'b1
  } gnt_sel_e;

  function automatic logic is_grant(input arb_state_e s);
    return (s == ST_GNT_D) || (s == ST_GNT_I);
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Bus-timeout watchdog: loaded when a grant starts, counts down while the
// memory request is outstanding and flags expiry on its final allowed cycle.
module mem_arb_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LOAD = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         run_q, run_d;

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (clear_i) begin
      cnt_d = '0;
      run_d = 1'b0;
    end else if (start_i) begin
      cnt_d = LOAD;
      run_d = 1'b1;
    end else if (run_q && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  // Count of zero corresponds to the TIMEOUT-th cycle of the request.
  assign expired_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch and
// data access, with starvation guard for fetch and a sticky bus-timeout flag.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic              err_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_e        state_q, state_d;
  gnt_sel_e          gsel_q;
  logic [SW-1:0]     starve_q, starve_d;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic [DATA_W-1:0] rdata_cap;
  logic              err_q;
  logic              in_grant, enter_d, enter_i, done, timed_out;
  logic              tmo_start, tmo_clear, tmo_expired;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (d_req_i && if_req_i)
          state_d = (starve_q == STARVE_LIM) ? ST_GNT_I : ST_GNT_D;
        else if (d_req_i)
          state_d = ST_GNT_D;
        else if (if_req_i)
          state_d = ST_GNT_I;
      end
      ST_GNT_D, ST_GNT_I: begin
        if (mem_ack_i || tmo_expired) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o = is_grant(state_q);
    if_ack_o  = (state_q == ST_RESP) && (gsel_q == GSEL_I);
    d_ack_o   = (state_q == ST_RESP) && (gsel_q == GSEL_D);
  end

  assign in_grant  = is_grant(state_q);
  assign enter_d   = (state_q == ST_IDLE) && (state_d == ST_GNT_D);
  assign enter_i   = (state_q == ST_IDLE) && (state_d == ST_GNT_I);
  assign done      = in_grant && (mem_ack_i || tmo_expired);
  // An ack arriving on the expiry cycle still wins over the timeout.
  assign timed_out = in_grant && tmo_expired && !mem_ack_i;
  assign tmo_start = enter_d || enter_i;
  assign tmo_clear = done;
  assign rdata_cap = (timed_out || mem_we_q) ? '0 : mem_rdata_i;

  always_comb begin
    starve_d = starve_q;
    if (enter_i)
      starve_d = '0;
    else if (enter_d) begin
      if (!if_req_i)                    starve_d = '0;
      else if (starve_q != STARVE_LIM)  starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      gsel_q      <= GSEL_D;
      starve_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      starve_q <= starve_d;
      if (enter_d) begin
        gsel_q      <= GSEL_D;
        mem_we_q    <= d_we_i;
        mem_addr_q  <= d_addr_i;
        mem_wdata_q <= d_wdata_i;
      end else if (enter_i) begin
        gsel_q      <= GSEL_I;
        mem_we_q    <= 1'b0;
        mem_addr_q  <= if_addr_i;
        mem_wdata_q <= '0;
      end
      if (done) begin
        if (gsel_q == GSEL_I) if_rdata_q <= rdata_cap;
        else                  d_rdata_q  <= rdata_cap;
      end
      if (timed_out) err_q <= 1'b1;
    end
  end

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (tmo_start),
    .clear_i   (tmo_clear),
    .expired_o (tmo_expired)
  );

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign err_o       = err_q;
  assign stall_o     = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter with a behavioural memory
// that acknowledges after a configurable number of request cycles.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        if_req_i, d_req_i, d_we_i, mem_ack_i;
  logic [31:0] if_addr_i, d_addr_i, d_wdata_i, mem_rdata_i;
  logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
  logic        if_ack_o, d_ack_o, mem_req_o, mem_we_o, stall_o, err_o;

  typedef struct packed {
    logic        is_i;
    logic [31:0] data;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  wait_cfg = 1;
  int  req_run = 0;
  int  last_req_len = 0;
  logic        first_we;
  logic [31:0] first_addr, first_wdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(64)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .stall_o(stall_o), .err_o(err_o)
  );

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return a ^ 32'h8C01_0014;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural memory: ack on the wait_cfg-th request cycle (0 = never).
  initial begin
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (mem_req_o) begin
        req_run++;
        if (req_run == 1) begin
          first_we    = mem_we_o;
          first_addr  = mem_addr_o;
          first_wdata = mem_wdata_o;
        end else begin
          chk("addr_stable", {32'd0, mem_addr_o}, {32'd0, first_addr});
          chk("wdata_stable", {32'd0, mem_wdata_o}, {32'd0, first_wdata});
        end
        if (wait_cfg != 0 && req_run == wait_cfg) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = mem_we_o ? 32'hDEAD_BEEF : rd_model(mem_addr_o);
        end else begin
          mem_ack_i   = 1'b0;
          mem_rdata_i = $urandom;
        end
      end else begin
        if (req_run != 0) last_req_len = req_run;
        req_run   = 0;
        mem_ack_i = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every ack must match the oldest outstanding expectation.
  initial begin
    sb_t it;
    forever begin
      @(negedge clk);
      if (rst_i && (if_ack_o || d_ack_o)) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", {62'd0, if_ack_o, d_ack_o}, 64'd0);
        end else begin
          it = sb.pop_front();
          chk("ack_port", {62'd0, if_ack_o, d_ack_o}, it.is_i ? 64'd2 : 64'd1);
          chk("rdata", {32'd0, (it.is_i ? if_rdata_o : d_rdata_o)}, {32'd0, it.data});
        end
      end
    end
  end

  task automatic wait_ack(input logic is_i, output int lat);
    lat = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (is_i ? if_ack_o : d_ack_o) break;
      lat++;
    end
    chk(is_i ? "if_ack_seen" : "d_ack_seen", {63'd0, (is_i ? if_ack_o : d_ack_o)}, 64'd1);
  endtask

  task automatic f_txn(input logic [31:0] addr, input logic [31:0] exp, output int lat);
    sb.push_back('{is_i: 1'b1, data: exp});
    @(posedge clk); #1;
    if_req_i  = 1'b1;
    if_addr_i = addr;
    wait_ack(1'b1, lat);
    @(posedge clk); #1;
    if_req_i = 1'b0;
  endtask

  task automatic d_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp, output int lat);
    sb.push_back('{is_i: 1'b0, data: exp});
    @(posedge clk); #1;
    d_req_i   = 1'b1;
    d_we_i    = we;
    d_addr_i  = addr;
    d_wdata_i = wdata;
    wait_ack(1'b0, lat);
    @(posedge clk); #1;
    d_req_i = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    rst_i = 1'b0;
    if_req_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0;
    if_addr_i = '0; d_addr_i = '0; d_wdata_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", {63'd0, mem_req_o}, 64'd0);
    chk("rst_acks", {62'd0, if_ack_o, d_ack_o}, 64'd0);
    chk("rst_err", {63'd0, err_o}, 64'd0);
    chk("rst_mem_bus", {mem_addr_o, mem_wdata_o}, 64'd0);
    chk("rst_rdata", {if_rdata_o, d_rdata_o}, 64'd0);
    chk("rst_stall", {63'd0, stall_o}, 64'd0);
    @(posedge clk); #1;
    rst_i = 1'b1;

    // Fetch only, zero-wait memory
    wait_cfg = 1;
    sb.push_back('{is_i: 1'b1, data: 32'h8C01_0004});
    @(posedge clk); #1;
    if_req_i = 1'b1; if_addr_i = 32'h10;
    @(negedge clk);
    chk("f_req_c0", {63'd0, mem_req_o}, 64'd0);
    chk("f_stall_c0", {63'd0, stall_o}, 64'd1);
    @(negedge clk);
    chk("f_req_c1", {63'd0, mem_req_o}, 64'd1);
    chk("f_stall_c1", {63'd0, stall_o}, 64'd1);
    chk("f_we_c1", {63'd0, mem_we_o}, 64'd0);
    @(negedge clk);
    chk("f_ack_c2", {63'd0, if_ack_o}, 64'd1);
    chk("f_stall_c2", {63'd0, stall_o}, 64'd0);
    chk("f_req_c2", {63'd0, mem_req_o}, 64'd0);
    @(posedge clk); #1;
    if_req_i = 1'b0;
    @(negedge clk);
    chk("f_ack_pulse", {63'd0, if_ack_o}, 64'd0);

    // Data store
    d_txn(1'b1, 32'h20, 32'h55, 32'h0, lat);
    chk("st_lat", lat, 2);
    chk("st_we", {63'd0, first_we}, 64'd1);
    chk("st_addr", {32'd0, first_addr}, 64'h20);
    chk("st_wdata", {32'd0, first_wdata}, 64'h55);
    chk("st_err", {63'd0, err_o}, 64'd0);

    // Contention with both requests held
    for (int k = 0; k < 10; k++)
      sb.push_back((k % 5 == 4) ? '{is_i: 1'b1, data: rd_model(32'h10)}
                                : '{is_i: 1'b0, data: rd_model(32'h40)});
    @(posedge clk); #1;
    if_req_i = 1'b1; if_addr_i = 32'h10;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h40; d_wdata_i = 32'h0;
    n = 0;
    for (int i = 0; i < 300 && n < 10; i++) begin
      @(negedge clk);
      if (if_ack_o || d_ack_o) n++;
    end
    @(posedge clk); #1;
    if_req_i = 1'b0; d_req_i = 1'b0;
    chk("cont_acks", n, 10);
    chk("cont_sb_empty", sb.size(), 0);

    // Wait states
    wait_cfg = 5;
    d_txn(1'b1, 32'h24, 32'hA5A5_0001, 32'h0, lat);
    chk("ws_lat", lat, 6);
    chk("ws_req_len", last_req_len, 5);
    chk("ws_addr", {32'd0, first_addr}, 64'h24);

    // Timeout
    wait_cfg = 0;
    d_txn(1'b0, 32'h30, 32'h0, 32'h0, lat);
    chk("tmo_lat", lat, 65);
    chk("tmo_req_len", last_req_len, 64);
    chk("tmo_err", {63'd0, err_o}, 64'd1);
    wait_cfg = 1;
    f_txn(32'h14, rd_model(32'h14), lat);
    chk("post_tmo_lat", lat, 2);
    chk("post_tmo_err", {63'd0, err_o}, 64'd1);

    // Reset while a data grant is outstanding
    wait_cfg = 5;
    @(posedge clk); #1;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h50;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req_o) break;
    end
    chk("rst_mid_req_seen", {63'd0, mem_req_o}, 64'd1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("rst_mid_req", {63'd0, mem_req_o}, 64'd0);
    chk("rst_mid_err", {63'd0, err_o}, 64'd0);
    chk("rst_mid_ack", {63'd0, d_ack_o}, 64'd0);
    @(posedge clk); #1;
    d_req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (d_ack_o || if_ack_o) n++;
    end
    chk("rst_no_ack", n, 0);
    d_txn(1'b0, 32'h50, 32'h0, rd_model(32'h50), lat);
    chk("rst_reissue_lat", lat, 6);
    chk("rst_reissue_err", {63'd0, err_o}, 64'd0);

    repeat (2) @(negedge clk);
    chk("final_sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
